// File: rtl/sync_fifo_mw.sv
// Multi-lane synchronous FIFO: accepts 0..N words and delivers 0..M words per cycle,
// with any-depth pointer wrap, almost-full/empty thresholds, sticky error flags and flush.
module sync_fifo_mw #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int N          = 4,
  parameter int M          = 2,
  parameter int AF_THRESH  = 24,
  parameter int AE_THRESH  = 2,
  parameter int INIT_FIFO  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [N*DATA_WIDTH-1:0]      data_in,
  input  logic [$clog2(N+1)-1:0]       wr_cnt,
  output logic [$clog2(N+1)-1:0]       slots_avail,
  output logic [M*DATA_WIDTH-1:0]      data_out,
  input  logic [$clog2(M+1)-1:0]       rd_cnt,
  output logic [$clog2(M+1)-1:0]       words_avail,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         afull,
  output logic                         aempty,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         err_clr
);

  localparam int CW = $clog2(N+1);
  localparam int RW = $clog2(M+1);
  localparam int FW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [FW-1:0]         fill_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic [FW-1:0]         space_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic [CW-1:0]         wr_acc_s;
  logic [RW-1:0]         rd_acc_s;

  // Wrap by subtraction so non-power-of-two depths index correctly.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [PW:0] k);
    logic [PW:0] sum;
    sum = {1'b0, ptr} + k;
    if (sum >= (PW+1)'(DEPTH)) begin
      ptr_add = PW'(sum - (PW+1)'(DEPTH));
    end else begin
      ptr_add = PW'(sum);
    end
  endfunction

  // Availability, flags and acceptance decisions from registered state only.
  always_comb begin
    space_s = FW'(DEPTH) - fill_r;
    if (space_s >= FW'(N)) begin
      slots_avail = CW'(N);
    end else begin
      slots_avail = CW'(space_s);
    end
    if (fill_r >= FW'(M)) begin
      words_avail = RW'(M);
    end else begin
      words_avail = RW'(fill_r);
    end
    wr_ok_s   = (wr_cnt <= slots_avail);
    rd_ok_s   = (rd_cnt <= words_avail);
    wr_acc_s  = wr_ok_s ? wr_cnt : {CW{1'b0}};
    rd_acc_s  = rd_ok_s ? rd_cnt : {RW{1'b0}};
    fill      = fill_r;
    afull     = (int'(fill_r) >= AF_THRESH);
    aempty    = (int'(fill_r) <= AE_THRESH);
    overflow  = overflow_r;
    underflow = underflow_r;
  end

  // Read lanes beyond the available word count are forced to zero.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < M; i++) begin
      if (RW'(i) < words_avail) begin
        data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem_r[ptr_add(rd_ptr_r, (PW+1)'(i))];
      end else begin
        data_out[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Pointers, occupancy and sticky error flags; flush outranks everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      fill_r      <= (INIT_FIFO != 0) ? FW'(DEPTH) : {FW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      fill_r      <= {FW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r    <= ptr_add(wr_ptr_r, (PW+1)'(wr_acc_s));
      rd_ptr_r    <= ptr_add(rd_ptr_r, (PW+1)'(rd_acc_s));
      fill_r      <= fill_r + FW'(wr_acc_s) - FW'(rd_acc_s);
      overflow_r  <= (!wr_ok_s) | (overflow_r & !err_clr);
      underflow_r <= (!rd_ok_s) | (underflow_r & !err_clr);
    end
  end

  // Storage: only whole accepted writes land, lane 0 at wr_ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_r[j] <= (INIT_FIFO != 0) ? DATA_WIDTH'(j) : {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!flush && wr_ok_s && (CW'(i) < wr_cnt)) begin
          mem_r[ptr_add(wr_ptr_r, (PW+1)'(i))] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule
